// File: rtl/stack_calc_pkg.sv
// Shared definitions for the stack calculator: opcodes, FSM states, LIFO commands
// and per-opcode stack requirements. Optional build macro: STACK_CALC_CARRY_EN.
package stack_calc_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_PUSH = 4'h1;
    localparam logic [3:0] OP_POP  = 4'h2;
    localparam logic [3:0] OP_OUTL = 4'h3;
    localparam logic [3:0] OP_OUTH = 4'h4;
    localparam logic [3:0] OP_SWAP = 4'h5;
    localparam logic [3:0] OP_PEEK = 4'h6;
    localparam logic [3:0] OP_DUP  = 4'h7;
    localparam logic [3:0] OP_AND  = 4'h8;
    localparam logic [3:0] OP_OR   = 4'h9;
    localparam logic [3:0] OP_XOR  = 4'hA;
    localparam logic [3:0] OP_ADD  = 4'hB;
    localparam logic [3:0] OP_SUB  = 4'hC;
    localparam logic [3:0] OP_INC  = 4'hD;
    localparam logic [3:0] OP_DEC  = 4'hE;
    localparam logic [3:0] OP_ADDC = 4'hD;
    localparam logic [3:0] OP_SUBC = 4'hE;
    localparam logic [3:0] OP_NOT  = 4'hF;

    typedef enum logic {ST_FETCH, ST_EXEC} state_t;

    typedef enum logic [2:0] {
        LIFO_NONE, LIFO_PUSH, LIFO_POP, LIFO_REPLACE, LIFO_POP_REPLACE, LIFO_SWAP
    } lifo_cmd_t;

    typedef struct packed {
        logic [1:0] need;   // entries that must be present
        logic       push;   // op grows the stack by one
    } op_info_t;

    function automatic op_info_t op_info(input logic [3:0] op);
        op_info_t info;
        info = '0;
        case (op)
            OP_PUSH:                               info.push = 1'b1;
            OP_POP, OP_OUTL, OP_OUTH, OP_NOT:      info.need = 2'd1;
            OP_DUP: begin
                info.need = 2'd1;
                info.push = 1'b1;
            end
            OP_PEEK: begin
                info.need = 2'd2;
                info.push = 1'b1;
            end
            OP_SWAP, OP_AND, OP_OR, OP_XOR,
            OP_ADD, OP_SUB:                        info.need = 2'd2;
`ifdef STACK_CALC_CARRY_EN
            OP_ADDC, OP_SUBC:                      info.need = 2'd2;
`else
            OP_INC, OP_DEC:                        info.need = 2'd1;
`endif
            default: ;
        endcase
        return info;
    endfunction

endpackage

// File: rtl/stack_calc_lifo.sv
// Stack storage with a single registered write port; entries at or above sp
// are never driven onto the outputs.
module stack_calc_lifo
    import stack_calc_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  lifo_cmd_t                  cmd,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           top_word,
    output logic [WIDTH-1:0]           second_word,
    output logic [$clog2(DEPTH+1)-1:0] depth
);
    localparam int AW  = $clog2(DEPTH);
    localparam int SPW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [SPW-1:0]   sp;
    logic [AW-1:0]    top_idx, sec_idx, push_idx;

    assign top_idx  = AW'(sp - SPW'(1));
    assign sec_idx  = AW'(sp - SPW'(2));
    assign push_idx = AW'(sp);

    assign depth       = sp;
    assign top_word    = (sp >= SPW'(1)) ? mem[top_idx] : '0;
    assign second_word = (sp >= SPW'(2)) ? mem[sec_idx] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            sp <= '0;
        end else begin
            case (cmd)
                LIFO_PUSH:                  sp <= sp + SPW'(1);
                LIFO_POP, LIFO_POP_REPLACE: sp <= sp - SPW'(1);
                default: ;
            endcase
        end
    end

    // Storage is not reset; sp alone defines which entries are meaningful.
    always_ff @(posedge clk) begin
        if (!rst) begin
            case (cmd)
                LIFO_PUSH:        mem[push_idx] <= wdata;
                LIFO_REPLACE:     mem[top_idx]  <= wdata;
                LIFO_POP_REPLACE: mem[sec_idx]  <= wdata;
                LIFO_SWAP: begin
                    mem[top_idx] <= mem[sec_idx];
                    mem[sec_idx] <= mem[top_idx];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/stack_calc_core.sv
// Stack calculator core: fetch/execute FSM, ALU, flags and sticky error checks.
// Optional build macro STACK_CALC_CARRY_EN turns opcodes D/E into ADDC/SUBC.
//
// state    | meaning
// ST_FETCH | op_ready=1, latch opcode/operand when op_valid
// ST_EXEC  | op_ready=0, apply the latched op to stack/flags/out_word
module stack_calc_core
    import stack_calc_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       op_valid,
    output logic                       op_ready,
    input  logic [3:0]                 opcode,
    input  logic [WIDTH-1:0]           operand,
    output logic [WIDTH-1:0]           top_word,
    output logic [WIDTH-1:0]           second_word,
    output logic [2*WIDTH-1:0]         out_word,
    output logic [$clog2(DEPTH+1)-1:0] depth,
    output logic                       flag_c,
    output logic                       flag_z,
    output logic                       err_overflow,
    output logic                       err_underflow
);
    localparam int SPW = $clog2(DEPTH+1);

    state_t             state, state_next;
    logic [3:0]         op_q;
    logic [WIDTH-1:0]   opd_q;
    op_info_t           info;
    lifo_cmd_t          lifo_cmd;
    logic [WIDTH-1:0]   lifo_wdata;
    logic [WIDTH-1:0]   a, b, alu_res;
    logic [WIDTH:0]     wide;
    logic               alu_c;
    logic               c_next, z_next, ovf_next, unf_next;
    logic [2*WIDTH-1:0] out_next;

    assign a    = second_word;
    assign b    = top_word;
    assign info = op_info(op_q);

    always_comb begin
        wide    = '0;
        alu_res = '0;
        alu_c   = 1'b0;
        case (op_q)
            OP_AND: alu_res = a & b;
            OP_OR:  alu_res = a | b;
            OP_XOR: alu_res = a ^ b;
            OP_ADD: wide = {1'b0, a} + {1'b0, b};
            OP_SUB: wide = {1'b0, a} - {1'b0, b};
`ifdef STACK_CALC_CARRY_EN
            OP_ADDC: wide = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, flag_c};
            OP_SUBC: wide = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, flag_c};
`else
            OP_INC:  wide = {1'b0, b} + {{WIDTH{1'b0}}, 1'b1};
            OP_DEC:  wide = {1'b0, b} - {{WIDTH{1'b0}}, 1'b1};
`endif
            OP_NOT: alu_res = ~b;
            default: ;
        endcase
        // Bit WIDTH of the extended result is carry for adds and borrow for subtracts.
        if (op_q inside {OP_ADD, OP_SUB, OP_INC, OP_DEC})
            {alu_c, alu_res} = wide;
    end

    always_comb begin
        state_next = state;
        op_ready   = (state == ST_FETCH);
        lifo_cmd   = LIFO_NONE;
        lifo_wdata = '0;
        c_next     = flag_c;
        z_next     = flag_z;
        out_next   = out_word;
        ovf_next   = err_overflow;
        unf_next   = err_underflow;
        case (state)
            ST_FETCH: if (op_valid) state_next = ST_EXEC;
            ST_EXEC: begin
                state_next = ST_FETCH;
                if (depth < SPW'(info.need)) begin
                    unf_next = 1'b1;
                end else if (info.push && depth == SPW'(DEPTH)) begin
                    ovf_next = 1'b1;
                end else if (op_q[3]) begin
                    lifo_cmd   = (info.need == 2'd2) ? LIFO_POP_REPLACE : LIFO_REPLACE;
                    lifo_wdata = alu_res;
                    c_next     = alu_c;
                    z_next     = (alu_res == '0);
                end else begin
                    case (op_q)
                        OP_PUSH: begin
                            lifo_cmd   = LIFO_PUSH;
                            lifo_wdata = opd_q;
                        end
                        OP_POP:  lifo_cmd = LIFO_POP;
                        OP_OUTL: out_next[WIDTH-1:0] = b;
                        OP_OUTH: out_next[2*WIDTH-1:WIDTH] = b;
                        OP_SWAP: lifo_cmd = LIFO_SWAP;
                        OP_PEEK: begin
                            lifo_cmd   = LIFO_PUSH;
                            lifo_wdata = a;
                        end
                        OP_DUP: begin
                            lifo_cmd   = LIFO_PUSH;
                            lifo_wdata = b;
                        end
                        default: ;
                    endcase
                end
            end
            default: state_next = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_FETCH;
            op_q          <= '0;
            opd_q         <= '0;
            flag_c        <= 1'b0;
            flag_z        <= 1'b0;
            out_word      <= '0;
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            state <= state_next;
            if (state == ST_FETCH && op_valid) begin
                op_q  <= opcode;
                opd_q <= operand;
            end
            flag_c        <= c_next;
            flag_z        <= z_next;
            out_word      <= out_next;
            err_overflow  <= ovf_next;
            err_underflow <= unf_next;
        end
    end

    stack_calc_lifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_lifo (
        .clk         (clk),
        .rst         (rst),
        .cmd         (lifo_cmd),
        .wdata       (lifo_wdata),
        .top_word    (top_word),
        .second_word (second_word),
        .depth       (depth)
    );

endmodule

// File: doc/stack_calc_core.md
Name: stack_calc_core

Overview:
Parametrised successor of the 4-bit stack CPU core. It has a configurable word width and stack depth, a full ALU opcode set, and carry/zero flags. It reports overflow and underflow errors instead of silently corrupting the stack. It sits between the pad-level io wrapper and the output mux/7-segment decoder, and takes opcodes and operands through a valid/ready handshake.

Parameters:
WIDTH, 4, data word width in bits (>=2)
DEPTH, 8, stack entries (power of two, >=2)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
op_valid  in  1  opcode/operand presented
op_ready  out  1  core accepts an op this cycle
opcode  in  4  operation, see Behaviour
operand  in  WIDTH  immediate for PUSH
top_word  out  WIDTH  stack[sp-1]; 0 when empty
second_word  out  WIDTH  stack[sp-2]; 0 when depth<2
out_word  out  2*WIDTH  output latch (OUTL/OUTH target)
depth  out  $clog2(DEPTH+1)  current entry count
flag_c  out  1  carry/borrow from last arithmetic op
flag_z  out  1  last ALU result == 0
err_overflow  out  1  sticky: push attempted when full
err_underflow  out  1  sticky: op needed more entries than present

Behaviour:
- Reset (clk edge with rst=1) applies in any state. It aborts any in-flight op with no stack write. Outputs after reset: depth=0, out_word=0, flag_c=0, flag_z=0, both err=0, op_ready=1, state FETCH.
- FSM has two states, FETCH and EXEC.
  - FETCH: op_ready=1. If op_valid=1, latch opcode and operand, go to EXEC. Otherwise stay.
  - EXEC: op_ready=0. Perform the op, update stack/flags/out_word on this edge, return to FETCH.
- Throughput is one op per 2 cycles. Results are visible on top_word the cycle after EXEC.
- Opcodes. Notation: a=second, b=top. "pop2 push1" means the net depth change is -1.
  - 0 NOP
  - 1 PUSH operand
  - 2 POP
  - 3 OUTL: out_word[WIDTH-1:0]=b
  - 4 OUTH: out_word[2W-1:W]=b
  - 5 SWAP
  - 6 PEEK: push a
  - 7 DUP: push b
  - 8 AND, 9 OR, A XOR: pop2, push a op b
  - B ADD: pop2, push a+b; c = carry out
  - C SUB: pop2, push a-b; c = borrow (a<b)
  - D INC: b=b+1; c = carry
  - E DEC: b=b-1; c = borrow
  - F NOT: b=~b
- Required depth: 1 for POP, OUTL, OUTH, D-F, and for DUP. 2 for SWAP, PEEK, and 8-C.
- Net push (PUSH, PEEK, DUP) when depth==DEPTH: stack unchanged, err_overflow set.
- Insufficient depth: stack, flags and out_word unchanged; err_underflow set.
- Error flags are sticky until rst.
- flag_z and flag_c update only on 8-F. Logic ops (8-A, F) clear flag_c.
- Arithmetic is modulo 2^WIDTH. Storage for entries beyond depth holds don't-care values, and they are never exposed.
- Opcode/operand changes while op_ready=0 are ignored.

Optional Feature:
STACK_CALC_CARRY_EN
- Defined: opcodes D and E become ADDC (pop2, push a+b+c) and SUBC (pop2, push a-b-c). Both require depth 2 and update c and z.
- Undefined: D/E are INC/DEC as above, and flag_c is never consumed.

Decomposition:
- Package stack_calc_pkg holds:
  - opcode localparams OP_NOP..OP_NOT (including OP_ADDC/OP_SUBC aliases)
  - FSM state enum {ST_FETCH, ST_EXEC}
  - per-opcode required-depth and net-push constants, as a function
- Sub-module stack_calc_lifo(WIDTH, DEPTH) holds:
  - the storage array and sp
  - a registered write port (push, pop, replace-top, pop-and-replace, swap)
  - top/second/depth outputs
- The core contains the FSM, the ALU and the error checks.

Test Plan:
- WIDTH=4, DEPTH=8. After rst: PUSH 3, PUSH 5, ADD -> top_word=8, depth=1, flag_c=0, flag_z=0; op_ready low exactly 1 cycle per op.
- PUSH F, PUSH 1, ADD -> top=0, flag_c=1, flag_z=1. Then PUSH 2, SUB -> top=E, flag_c=1.
- 9 × PUSH 1 -> depth=8 after the 8th; 9th leaves depth=8 and sets err_overflow. Then POP, PUSH 2 succeeds (top=2) and err_overflow stays 1.
- Empty stack, ADD -> depth=0, top_word=0, err_underflow=1, flags unchanged. PUSH 7, OUTL, PUSH A, OUTH -> out_word=8'hA7.
- PUSH 1, PUSH 2, SWAP -> top=1, second=2. PEEK -> top=2, depth=3. DUP, XOR -> top=0, flag_z=1.
- Assert rst during EXEC of PUSH 4 -> no write, depth=0, op_ready=1 next cycle. With STACK_CALC_CARRY_EN: PUSH F, PUSH 1, ADD, PUSH 0, PUSH 0, ADDC -> top=1.
